// File: rtl/inst_mem_loader_pkg.sv
// inst_mem_loader_pkg: shared definitions for the instruction memory loader,
// the instruction memory, the program counter and the decoder.
package inst_mem_loader_pkg;

    // Default encoded instruction width
    localparam int unsigned INST_W_DEFAULT = 8;

    // Loader states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    // Instruction fields: opcode in the top bits, operand below
    localparam int unsigned OPC_W   = 3;
    localparam int unsigned OPC_LSB = INST_W_DEFAULT - OPC_W;
    localparam int unsigned OPD_W   = OPC_LSB;

    localparam logic [OPC_W-1:0] OPC_NOP = 3'd0;
    localparam logic [OPC_W-1:0] OPC_LDI = 3'd1;
    localparam logic [OPC_W-1:0] OPC_ADD = 3'd2;
    localparam logic [OPC_W-1:0] OPC_SUB = 3'd3;
    localparam logic [OPC_W-1:0] OPC_JMP = 3'd4;
    localparam logic [OPC_W-1:0] OPC_JZ  = 3'd5;
    localparam logic [OPC_W-1:0] OPC_OUT = 3'd6;
    localparam logic [OPC_W-1:0] OPC_HLT = 3'd7;

    // Extract the opcode field from an encoded instruction
    function automatic logic [OPC_W-1:0] opcode_of(input logic [INST_W_DEFAULT-1:0] inst);
        return inst[OPC_LSB +: OPC_W];
    endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// inst_mem_loader_if: load request, byte stream and memory write port of the
// instruction memory loader. slave = loader side, master = source side.
interface inst_mem_loader_if
    import inst_mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned INST_W = INST_W_DEFAULT
) ();
    logic              start_i;
    logic [ADDR_W-1:0] last_i;
    logic              in_valid_i;
    logic [INST_W-1:0] in_data_i;
    logic              in_ready_o;
    logic              we_o;
    logic [ADDR_W-1:0] waddr_o;
    logic [INST_W-1:0] wdata_o;
    logic              run_o;
    logic              busy_o;
    logic              err_o;

    modport slave (
        input  start_i, last_i, in_valid_i, in_data_i,
        output in_ready_o, we_o, waddr_o, wdata_o, run_o, busy_o, err_o
    );

    modport master (
        output start_i, last_i, in_valid_i, in_data_i,
        input  in_ready_o, we_o, waddr_o, wdata_o, run_o, busy_o, err_o
    );
endinterface

// File: rtl/inst_mem_loader_xor_accum.sv
// xor_accum: running XOR of a byte stream with synchronous clear and enable.
// Only built when INST_LOADER_CHECKSUM_EN is defined, the sole consumer.
`ifdef INST_LOADER_CHECKSUM_EN
module xor_accum #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc
);
    // Clear wins over accumulate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= acc ^ din;
    end
endmodule
`endif

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: streams instruction bytes into the instruction memory at
// consecutive addresses from 0, then releases the core via run_o.
// Optional trailing XOR checksum byte: INST_LOADER_CHECKSUM_EN.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned INST_W = INST_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    inst_mem_loader_if.slave  bus
);
    state_t            state_q, state_nxt;
    logic [ADDR_W-1:0] cnt_q, last_q;
    logic              ready_q, busy_q, run_q, we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [INST_W-1:0] wdata_q;
    logic              start_ok, hs_load;

`ifdef INST_LOADER_CHECKSUM_EN
    logic [INST_W-1:0] acc;
    logic              err_q;

    xor_accum #(.W(INST_W)) u_xor_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .en    (hs_load),
        .din   (bus.in_data_i),
        .acc   (acc)
    );
`endif

    // Next-state: accept start when not busy, count bytes, finish on the last
    always_comb begin
        state_nxt = state_q;
        start_ok  = 1'b0;
        hs_load   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start_i) begin
                    start_ok  = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (bus.in_valid_i && ready_q) begin
                    hs_load = 1'b1;
                    // Compare before increment so last=2^ADDR_W-1 never wraps early
                    if (cnt_q == last_q) begin
`ifdef INST_LOADER_CHECKSUM_EN
                        state_nxt = ST_CHECK;
`else
                        state_nxt = ST_DONE;
`endif
                    end
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (bus.in_valid_i && ready_q)
                    state_nxt = (bus.in_data_i == acc) ? ST_DONE : ST_ERROR;
            end
            ST_ERROR: begin
                if (bus.start_i) begin
                    start_ok  = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register plus Moore status flags registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            run_q   <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_nxt;
            ready_q <= (state_nxt == ST_LOAD) || (state_nxt == ST_CHECK);
            busy_q  <= (state_nxt == ST_LOAD) || (state_nxt == ST_CHECK);
            run_q   <= (state_nxt == ST_DONE);
`ifdef INST_LOADER_CHECKSUM_EN
            err_q   <= (state_nxt == ST_ERROR);
`endif
        end
    end

    // Address counter and latched last address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            last_q <= '0;
        end else if (start_ok) begin
            cnt_q  <= '0;
            last_q <= bus.last_i;
        end else if (hs_load) begin
            cnt_q  <= cnt_q + ADDR_W'(1);
        end
    end

    // Registered write port: one-cycle pulse, address/data held between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= hs_load;
            if (hs_load) begin
                waddr_q <= cnt_q;
                wdata_q <= bus.in_data_i;
            end
        end
    end

    assign bus.in_ready_o = ready_q;
    assign bus.busy_o     = busy_q;
    assign bus.run_o      = run_q;
    assign bus.we_o       = we_q;
    assign bus.waddr_o    = waddr_q;
    assign bus.wdata_o    = wdata_q;
`ifdef INST_LOADER_CHECKSUM_EN
    assign bus.err_o      = err_q;
`else
    assign bus.err_o      = 1'b0;
`endif

endmodule
